// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus arbiter: address prefix map,
// FSM state encoding and the prefix-field width.
package periph_pkg;

    localparam int PREFIX_W = 3;

    localparam logic [PREFIX_W-1:0] PFX_RAM      = 3'b000;
    localparam logic [PREFIX_W-1:0] PFX_PWM1     = 3'b001;
    localparam logic [PREFIX_W-1:0] PFX_BTN      = 3'b010;
    localparam logic [PREFIX_W-1:0] PFX_UNMAPPED = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } arb_state_t;

    // RAM is not reachable through this manager and 111 has no target.
    function automatic logic prefix_is_error(input logic [31:0] addr);
        return (addr[31:32-PREFIX_W] == PFX_RAM) ||
               (addr[31:32-PREFIX_W] == PFX_UNMAPPED);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin selector; remembers which requester was served last
// so that simultaneous requests alternate.
module rr_picker #(
    parameter int RESET_PRIO = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic grant_valid,
    output logic grant_sel
);

    logic last_served;

    // Reset value points away from RESET_PRIO so that it wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_served <= (RESET_PRIO == 0) ? 1'b1 : 1'b0;
        else if (take && grant_valid)
            last_served <= grant_sel;
    end

    always_comb begin
        grant_valid = req0 | req1;
        grant_sel   = (req0 && req1) ? ~last_served : req1;
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-requester arbiter in front of the peripheral manager.
// Define PERIPH_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES.
//
// state      | meaning
// ST_IDLE    | waiting for a request; latches the winner
// ST_ACCESS  | downstream access in flight, waits for p_ready
// ST_RESPOND | result is registered onto the winner's ack/err/rdata
module periph_bus_arbiter
    import periph_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESET_PRIO     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] p_addr,
    output logic [31:0] p_data_in,
    output logic        p_write_enable,
    input  logic [31:0] p_data_out,
    input  logic        p_ready
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    arb_state_t  state, state_nxt;
    logic        grant_valid, grant_sel, take;
    logic        win_we, win_err;
    logic [31:0] win_addr, win_wdata;
    logic        lat_sel, lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [TMR_W-1:0] tmr;
    logic        timeout_en, timed_out;
    logic        m0_ack_d, m1_ack_d, m0_err_d, m1_err_d, p_we_d;
    logic [31:0] m0_rdata_d, m1_rdata_d, p_addr_d, p_data_in_d;

`ifdef PERIPH_ARB_TIMEOUT_EN
    assign timeout_en = 1'b1;
`else
    assign timeout_en = 1'b0;
`endif

    assign take      = (state == ST_IDLE);
    assign win_we    = grant_sel ? m1_we    : m0_we;
    assign win_addr  = grant_sel ? m1_addr  : m0_addr;
    assign win_wdata = grant_sel ? m1_wdata : m0_wdata;
    assign win_err   = prefix_is_error(win_addr);
    assign timed_out = timeout_en && (tmr == '0);

    rr_picker #(.RESET_PRIO(RESET_PRIO)) u_rr_picker (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (m0_req),
        .req1        (m1_req),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (grant_valid) state_nxt = win_err ? ST_RESPOND : ST_ACCESS;
            ST_ACCESS:  if (p_ready || timed_out) state_nxt = ST_RESPOND;
            ST_RESPOND: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Latched transaction and its result; p_ready takes precedence over timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sel    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            tmr        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmr <= TMR_LOAD;
                    if (grant_valid) begin
                        lat_sel    <= grant_sel;
                        lat_we     <= win_we;
                        lat_addr   <= win_addr;
                        lat_wdata  <= win_wdata;
                        resp_err   <= win_err;
                        resp_rdata <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (tmr != '0) tmr <= tmr - 1'b1;
                    if (p_ready) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_we ? 32'd0 : p_data_out;
                    end else if (timed_out) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        p_addr_d    = '0;
        p_data_in_d = '0;
        p_we_d      = 1'b0;
        if (state_nxt == ST_ACCESS) begin
            p_addr_d    = (state == ST_IDLE) ? win_addr  : lat_addr;
            p_data_in_d = (state == ST_IDLE) ? win_wdata : lat_wdata;
            p_we_d      = (state == ST_IDLE) && win_we;
        end
        m0_ack_d   = (state == ST_RESPOND) && !lat_sel;
        m1_ack_d   = (state == ST_RESPOND) &&  lat_sel;
        m0_err_d   = m0_ack_d && resp_err;
        m1_err_d   = m1_ack_d && resp_err;
        m0_rdata_d = m0_ack_d ? resp_rdata : 32'd0;
        m1_rdata_d = m1_ack_d ? resp_rdata : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_addr         <= '0;
            p_data_in      <= '0;
            p_write_enable <= 1'b0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
            m0_err         <= 1'b0;
            m1_err         <= 1'b0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
        end else begin
            p_addr         <= p_addr_d;
            p_data_in      <= p_data_in_d;
            p_write_enable <= p_we_d;
            m0_ack         <= m0_ack_d;
            m1_ack         <= m1_ack_d;
            m0_err         <= m0_err_d;
            m1_err         <= m1_err_d;
            m0_rdata       <= m0_rdata_d;
            m1_rdata       <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter; timeout checks follow
// PERIPH_ARB_TIMEOUT_EN.
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] p_addr, p_data_in, p_data_out;
    logic        p_write_enable, p_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.TIMEOUT_CYCLES(16), .RESET_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .p_addr(p_addr), .p_data_in(p_data_in), .p_write_enable(p_write_enable),
        .p_data_out(p_data_out), .p_ready(p_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        p_data_out = 0; p_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [135:0] outs;
        apply_reset();
        outs = {m0_ack, m1_ack, m0_err, m1_err, p_write_enable, m0_rdata, m1_rdata, p_addr, p_data_in};
        checks++;
        if (outs !== 136'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
    endtask

    task automatic test_write();
        apply_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h2000_0000; m0_wdata = 32'd5;
        tick();
        checks++;
        if (p_write_enable !== 1'b1 || p_data_in !== 32'd5 || p_addr !== 32'h2000_0000 || m0_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_strobe got we=%b din=%h addr=%h ack=%b want we=1 din=5 addr=20000000 ack=0",
                     p_write_enable, p_data_in, p_addr, m0_ack);
        end
        tick();
        checks++;
        if (p_write_enable !== 1'b0 || p_addr !== 32'd0 || m0_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_respond got we=%b addr=%h ack=%b want we=0 addr=0 ack=0",
                     p_write_enable, p_addr, m0_ack);
        end
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'd0 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL write_ack got ack=%b err=%b rdata=%h m1_ack=%b want ack=1 err=0 rdata=0 m1_ack=0",
                     m0_ack, m0_err, m0_rdata, m1_ack);
        end
        m0_req = 0;
        tick();
        checks++;
        if (m0_ack !== 1'b0 || p_addr !== 32'd0) begin
            failures++;
            $display("FAIL write_after got ack=%b addr=%h want ack=0 addr=0", m0_ack, p_addr);
        end
    endtask

    task automatic test_round_robin();
        int m0_at = -1;
        int m1_at = -1;
        int n0 = 0;
        int n1 = 0;
        int overlap = 0;
        apply_reset();
        p_data_out = 32'd7;
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 32'h4000_0001; m1_addr = 32'h4000_0001;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (m0_ack && m1_ack) overlap++;
            if (m0_ack) begin
                n0++; m0_at = c; m0_req = 0;
                checks++;
                if (m0_rdata !== 32'd7 || m0_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_m0_data got rdata=%h err=%b want rdata=7 err=0", m0_rdata, m0_err);
                end
            end
            if (m1_ack) begin
                n1++; m1_at = c; m1_req = 0;
                checks++;
                if (m1_rdata !== 32'd7 || m1_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_m1_data got rdata=%h err=%b want rdata=7 err=0", m1_rdata, m1_err);
                end
            end
        end
        checks++;
        if (m0_at != 3 || m1_at != 6 || n0 != 1 || n1 != 1 || overlap != 0) begin
            failures++;
            $display("FAIL rr_order got m0_at=%0d m1_at=%0d n0=%0d n1=%0d overlap=%0d want 3 6 1 1 0",
                     m0_at, m1_at, n0, n1, overlap);
        end
    endtask

    task automatic test_ram_error();
        apply_reset();
        p_data_out = 32'hDEAD_BEEF;
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0010;
        tick();
        checks++;
        if (p_write_enable !== 1'b0 || p_addr !== 32'd0 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL err_skip got we=%b addr=%h ack=%b want we=0 addr=0 ack=0",
                     p_write_enable, p_addr, m1_ack);
        end
        tick();
        checks++;
        if (m1_ack !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'd0 || m0_ack !== 1'b0 || p_write_enable !== 1'b0) begin
            failures++;
            $display("FAIL err_ack got ack=%b err=%b rdata=%h m0_ack=%b we=%b want 1 1 0 0 0",
                     m1_ack, m1_err, m1_rdata, m0_ack, p_write_enable);
        end
        m1_req = 0;
        tick();
    endtask

    task automatic test_timeout();
        int ack_at = -1;
        apply_reset();
        p_ready = 0; p_data_out = 32'h1234_5678;
        m0_req = 1; m0_we = 0; m0_addr = 32'h2000_0004;
`ifdef PERIPH_ARB_TIMEOUT_EN
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            tick();
            if (m0_ack) begin
                ack_at = c; m0_req = 0;
                checks++;
                if (m0_err !== 1'b1 || m0_rdata !== 32'd0) begin
                    failures++;
                    $display("FAIL timeout_resp got err=%b rdata=%h want err=1 rdata=0", m0_err, m0_rdata);
                end
            end
        end
        checks++;
        if (ack_at != 18) begin
            failures++;
            $display("FAIL timeout_latency got ack_at=%0d want 18", ack_at);
        end
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (m0_ack) ack_at = c;
        end
        checks++;
        if (ack_at != -1 || p_addr !== 32'h2000_0004) begin
            failures++;
            $display("FAIL wait_no_ack got ack_at=%0d addr=%h want -1 20000004", ack_at, p_addr);
        end
        p_ready = 1;
        tick();
        m0_req = 0;
        tick();
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL wait_release got ack=%b err=%b rdata=%h want 1 0 12345678", m0_ack, m0_err, m0_rdata);
        end
`endif
        p_ready = 1;
        m0_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int n0 = 0;
        int m1_at = -1;
        logic [135:0] outs;
        apply_reset();
        p_ready = 0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h2000_0008; m0_wdata = 32'd9;
        tick();
        m0_req = 0;
        tick();
        checks++;
        if (p_addr !== 32'h2000_0008 || p_data_in !== 32'd9) begin
            failures++;
            $display("FAIL mid_access got addr=%h din=%h want 20000008 9", p_addr, p_data_in);
        end
        #2 rst_n = 0;
        #1;
        outs = {m0_ack, m1_ack, m0_err, m1_err, p_write_enable, m0_rdata, m1_rdata, p_addr, p_data_in};
        checks++;
        if (outs !== 136'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h want=0", outs);
        end
        m1_req = 1; m1_we = 0; m1_addr = 32'h4000_0000; p_ready = 1; p_data_out = 32'd3;
        tick();
        rst_n = 1;
        tick();
        checks++;
        if (p_addr !== 32'h4000_0000) begin
            failures++;
            $display("FAIL post_reset_grant got addr=%h want 40000000", p_addr);
        end
        for (int c = 2; c <= 6; c++) begin
            tick();
            if (m0_ack) n0++;
            if (m1_ack) begin
                m1_at = c; m1_req = 0;
            end
        end
        checks++;
        if (n0 != 0 || m1_at != 3 || m1_rdata !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_m1 got m0_acks=%0d m1_at=%0d want 0 3", n0, m1_at);
        end
    endtask

    task automatic test_req_drop();
        int n0 = 0;
        int m0_at = -1;
        logic [31:0] rd = 0;
        apply_reset();
        p_data_out = 32'h55;
        m0_req = 1; m0_we = 0; m0_addr = 32'h2000_0000;
        tick();
        m0_req = 0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            if (m0_ack) begin
                n0++; m0_at = c; rd = m0_rdata;
            end
        end
        checks++;
        if (n0 != 1 || m0_at != 3 || rd !== 32'h55) begin
            failures++;
            $display("FAIL req_drop got acks=%0d at=%0d rdata=%h want 1 3 55", n0, m0_at, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_ram_error();
        test_timeout();
        test_reset_mid_access();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
